// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle byte-wide data memory with its own access
// controller. One load or store is accepted at a time; the core is stalled
// for LATENCY wait cycles, the array is accessed on the last wait edge and a
// one-cycle DONE state releases the stall. RdData holds the last loaded byte
// so the writeback mux sees stable data between loads.
// Optional feature macro: DMEM_PERF_EN adds saturating LoadCount/StoreCount.
module data_mem_ctrl #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int LATENCY = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          ReqValid,
  input  logic          ReqWrite,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] WrData,
  output logic          Stall,
  output logic          RdValid,
  output logic [DW-1:0] RdData
`ifdef DMEM_PERF_EN
  ,
  output logic [15:0]   LoadCount,
  output logic [15:0]   StoreCount
`endif
);

  // Wait counter only ever holds LATENCY-1, which tops out at 14.
  localparam int CW = 4;

  // A zero or oversized latency cannot be represented by the wait counter.
  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("data_mem_ctrl: LATENCY must be in the range 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          write_q;
  logic          access_edge;

  logic [DW-1:0] mem [0:(2**AW)-1];

  // The array is touched only on the final wait edge, using latched fields.
  assign access_edge = (state == S_WAIT) && (cnt == '0);

  // Hold the core while a request is being accepted or is in flight; DONE
  // releases it even though ReqValid is still high for that instruction.
  assign Stall = ((state == S_IDLE) && ReqValid) || (state == S_WAIT);

  // Request sequencing: latch on accept, count down the wait, complete loads.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      RdValid <= 1'b0;
      RdData  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      RdValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ReqValid) begin
            addr_q  <= Addr;
            wdata_q <= WrData;
            write_q <= ReqWrite;
            cnt     <= CW'(LATENCY - 1);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= S_DONE;
            if (!write_q) begin
              RdData  <= mem[addr_q];
              RdValid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Store commit; a reset landing on the access edge aborts the write.
  always_ff @(posedge Clk) begin
    if (!Reset && access_edge && write_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

`ifdef DMEM_PERF_EN
  // Count completed accesses by type during DONE, saturating at all-ones.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      LoadCount  <= '0;
      StoreCount <= '0;
    end else if (state == S_DONE) begin
      if (write_q) begin
        if (StoreCount != 16'hFFFF) StoreCount <= StoreCount + 16'd1;
      end else begin
        if (LoadCount != 16'hFFFF) LoadCount <= LoadCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed, self-checking bench for data_mem_ctrl with the
// default LATENCY of 2. Inputs change just after the falling edge and outputs
// are sampled 1 time unit later, well away from the rising edge.
module tb_data_mem_ctrl;

  localparam int LAT = 2;

  logic       Clk;
  logic       Reset;
  logic       ReqValid;
  logic       ReqWrite;
  logic [7:0] Addr;
  logic [7:0] WrData;
  logic       Stall;
  logic       RdValid;
  logic [7:0] RdData;
`ifdef DMEM_PERF_EN
  logic [15:0] LoadCount;
  logic [15:0] StoreCount;
`endif

  int vectors     = 0;
  int miscompares = 0;

  data_mem_ctrl #(.AW(8), .DW(8), .LATENCY(LAT)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqWrite (ReqWrite),
    .Addr     (Addr),
    .WrData   (WrData),
    .Stall    (Stall),
    .RdValid  (RdValid),
    .RdData   (RdData)
`ifdef DMEM_PERF_EN
    ,
    .LoadCount  (LoadCount),
    .StoreCount (StoreCount)
`endif
  );

  // Free-running 10-unit clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One complete access, checking Stall/RdValid every cycle up to the
  // following IDLE cycle. Optionally scrambles the inputs during WAIT.
  task automatic applyStimulus(input string tag, input logic wr,
                               input logic [7:0] a, input logic [7:0] d,
                               input logic [7:0] expRd, input logic scramble);
    ReqValid = 1'b1;
    ReqWrite = wr;
    Addr     = a;
    WrData   = d;
    for (int c = 0; c <= LAT; c++) begin
      #1;
      checkOutput({tag, " stall"}, {15'd0, Stall}, 16'd1);
      checkOutput({tag, " rdvalid-busy"}, {15'd0, RdValid}, 16'd0);
      if (scramble && c == 1) begin
        ReqWrite = ~wr;
        Addr     = ~a;
        WrData   = ~d;
      end
      @(negedge Clk);
    end
    #1;
    checkOutput({tag, " done-stall"}, {15'd0, Stall}, 16'd0);
    checkOutput({tag, " done-rdvalid"}, {15'd0, RdValid}, {15'd0, ~wr});
    checkOutput({tag, " done-rddata"}, {8'd0, RdData}, {8'd0, expRd});
    ReqWrite = wr;
    Addr     = a;
    WrData   = d;
    @(negedge Clk);
    ReqValid = 1'b0;
    #1;
    checkOutput({tag, " idle-rdvalid"}, {15'd0, RdValid}, 16'd0);
    checkOutput({tag, " idle-rddata"}, {8'd0, RdData}, {8'd0, expRd});
  endtask

  initial begin
    Reset    = 1'b1;
    ReqValid = 1'b0;
    ReqWrite = 1'b0;
    Addr     = 8'h00;
    WrData   = 8'h00;

    // Reset for two cycles, then idle with no request.
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checkOutput("reset stall", {15'd0, Stall}, 16'd0);
    checkOutput("reset rdvalid", {15'd0, RdValid}, 16'd0);
    checkOutput("reset rddata", {8'd0, RdData}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      #1;
      checkOutput("idle no-accept stall", {15'd0, Stall}, 16'd0);
    end
`ifdef DMEM_PERF_EN
    checkOutput("reset loadcount", LoadCount, 16'd0);
    checkOutput("reset storecount", StoreCount, 16'd0);
`endif
    @(negedge Clk);

    // Store 5A to 10, scrambling inputs mid-flight; RdData stays 00.
    applyStimulus("store 10", 1'b1, 8'h10, 8'h5A, 8'h00, 1'b1);

    // Load 10 back, then confirm the byte holds for five idle cycles.
    applyStimulus("load 10", 1'b0, 8'h10, 8'h00, 8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      #1;
      checkOutput("hold rddata", {8'd0, RdData}, 16'h005A);
      checkOutput("hold rdvalid", {15'd0, RdValid}, 16'd0);
    end
    @(negedge Clk);

    // Store 00 to 20, then abort a store of FF to 20 with reset in WAIT.
    applyStimulus("store 20", 1'b1, 8'h20, 8'h00, 8'h5A, 1'b0);
    ReqValid = 1'b1;
    ReqWrite = 1'b1;
    Addr     = 8'h20;
    WrData   = 8'hFF;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    checkOutput("abort wait stall", {15'd0, Stall}, 16'd1);
    @(negedge Clk);
    Reset    = 1'b0;
    ReqValid = 1'b0;
    #1;
    checkOutput("abort stall", {15'd0, Stall}, 16'd0);
    checkOutput("abort rddata", {8'd0, RdData}, 16'h0000);
    @(negedge Clk);
    applyStimulus("load 20", 1'b0, 8'h20, 8'h00, 8'h00, 1'b0);

    // Extreme addresses are distinct locations.
    applyStimulus("store FF", 1'b1, 8'hFF, 8'hAA, 8'h00, 1'b0);
    applyStimulus("store 00", 1'b1, 8'h00, 8'h55, 8'h00, 1'b0);
    applyStimulus("load FF", 1'b0, 8'hFF, 8'h00, 8'hAA, 1'b0);
    applyStimulus("load 00", 1'b0, 8'h00, 8'h00, 8'h55, 1'b0);

`ifdef DMEM_PERF_EN
    // Four loads and four stores so far since reset.
    checkOutput("perf loadcount", LoadCount, 16'd4);
    checkOutput("perf storecount", StoreCount, 16'd4);
    force dut.LoadCount = 16'hFFFF;
    @(negedge Clk);
    release dut.LoadCount;
    applyStimulus("load sat", 1'b0, 8'h10, 8'h00, 8'h5A, 1'b0);
    @(negedge Clk);
    #1;
    checkOutput("perf loadcount sat", LoadCount, 16'hFFFF);
    checkOutput("perf storecount hold", StoreCount, 16'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Multi-cycle data memory with its own access controller for the 3BC processor.
- Sits directly upstream of the writeback select mux: RdData drives the mux "memory" input (Sel=0, input A).
- Accepts one load or store request at a time and stalls the core for a fixed, parameterised latency.
- Holds the last loaded byte stable so the writeback path sees constant data.

Parameters:
- AW, 8, address width; memory depth is 2**AW bytes.
- DW, 8, data width.
- LATENCY, 2, array wait cycles per access; legal range 1..15; 0 is illegal and fails elaboration.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- ReqValid  input  1  memory instruction present; held high by the core until Stall drops.
- ReqWrite  input  1  1 = store, 0 = load; sampled when the request is accepted.
- Addr  input  AW  byte address; sampled when the request is accepted.
- WrData  input  DW  store data; sampled when the request is accepted.
- Stall  output  1  combinational; freezes PC and pipeline while high.
- RdValid  output  1  one-cycle pulse when a load completes.
- RdData  output  DW  last loaded byte; feeds writeback mux input A.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, on port Reset.
- Reset state: state=IDLE, counter=0, RdValid=0, RdData=0, latched request fields=0.
- Reset does not clear the memory array; contents are undefined until written.
- FSM states and transitions:
  - IDLE: if ReqValid=1, latch Addr, WrData and ReqWrite; counter<=LATENCY-1; go to WAIT.
  - WAIT: if counter!=0, decrement. If counter==0, perform the access on this edge and go to DONE.
  - DONE: unconditionally return to IDLE.
- Access edge (WAIT to DONE):
  - Store: mem[addr_q]<=wdata_q.
  - Load: RdData<=mem[addr_q]; RdValid<=1.
- RdValid is registered: high only in DONE, and only for loads.
- Stall=(state==IDLE && ReqValid) || state==WAIT. Stall is 0 in DONE, even though ReqValid is still high for the completing instruction.
- ReqValid seen in DONE is never treated as a new request. A new request is accepted in the following IDLE cycle.
- Timing: acceptance in cycle 0; Stall high for cycles 0..LATENCY; DONE in cycle LATENCY+1. An access costs LATENCY+2 cycles including DONE.
- Stores never modify RdData.
- RdData holds its value indefinitely between loads.
- Changes to ReqValid, Addr, WrData or ReqWrite during WAIT are ignored; the in-flight transaction completes with its latched values.
- Load after store to the same address returns the stored value, since accesses are strictly serialised.
- Addresses are AW bits exactly; there is no wrap logic. 0xFF and 0x00 are distinct locations.
- Reset during WAIT: the transaction is aborted, no memory write occurs, and the FSM returns to IDLE.
- Reset during DONE: a store has already committed; RdValid and RdData clear to 0.
- Reset takes priority over every other transition.

Optional Feature:
- Macro: DMEM_PERF_EN.
- Defined:
  - Adds outputs LoadCount and StoreCount, each 16 bits.
  - Each counter increments on the DONE cycle of its access type.
  - Counters saturate at 16'hFFFF and clear to 0 on Reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset high for 2 cycles, then low -> Stall=0, RdValid=0, RdData=8'h00; no request accepted while ReqValid=0.
2. Store 8'h5A to 8'h10 (LATENCY=2), ReqValid held until Stall drops -> Stall=1 in cycles 0,1,2; cycle 3 has Stall=0 and RdValid=0; RdData unchanged.
3. Load 8'h10 after test 2 -> RdValid=1 only in cycle 3; RdData=8'h5A from cycle 3 onward. It still holds 8'h5A 5 cycles later with ReqValid=0.
4. Store 8'h00 to 8'h20, then store 8'hFF to 8'h20 with Reset asserted in its first WAIT cycle, then load 8'h20 -> load returns 8'h00.
5. Store 8'hAA to 8'hFF, store 8'h55 to 8'h00, load 8'hFF, load 8'h00 -> RdData 8'hAA then 8'h55; each load shows exactly one RdValid pulse.
6. With DMEM_PERF_EN, 3 loads and 2 stores -> LoadCount=3, StoreCount=2. Preset to 16'hFFFF (force) plus one load -> LoadCount stays 16'hFFFF.
